// File: rtl/adf4360_seq_if.sv
// Command bus between the power-up sequencer and the single-word ADF4360
// SPI/CE controller: 24-bit command word, trigger strobe and idle flag.
interface adf4360_seq_if;
   logic [23:0] cmd;    // [23:22] latch address, [21:0] payload
   logic        trig;   // command strobe towards the controller
   logic        ready;  // controller idle flag

   // Sequencer side
   modport master (output cmd, output trig, input ready);
   // Controller side
   modport slave  (input cmd, input trig, output ready);
endinterface

// File: rtl/adf4360_seq.sv
// ADF4360 power-up and programming sequencer.
// On a start request it turns CE on, waits CE_SETTLE cycles, writes the R,
// Control and N latches (with CN_DELAY cycles between C and N), then reports
// completion. A power-down request issues a single CE-off command instead.
// Optional lock check after the N write: define ADF4360_LOCK_CHECK_EN.
module adf4360_seq #(
   parameter logic [23:0] CE_SETTLE    = 24'd1000,
   parameter logic [23:0] CN_DELAY     = 24'd5000,
   parameter logic [23:0] LOCK_TIMEOUT = 24'd1000000,
   parameter logic [23:0] LOCK_HOLD    = 24'd64
) (
   input  logic                 clk_i,
   input  logic                 reset_n_i,
   input  logic                 start_i,
   input  logic                 pd_i,
   input  logic [21:0]          r_data_i,
   input  logic [21:0]          c_data_i,
   input  logic [21:0]          n_data_i,
   input  logic                 lock_i,
   adf4360_seq_if.master        bus,
   output logic                 busy_o,
   output logic                 done_o,
   output logic                 locked_o,
   output logic                 error_o
);

   localparam logic [2:0] STATE_IDLE    = 3'd0;
   localparam logic [2:0] STATE_ISSUE   = 3'd1;
   localparam logic [2:0] STATE_GUARD   = 3'd2;
   localparam logic [2:0] STATE_WAITRDY = 3'd3;
   localparam logic [2:0] STATE_SETTLE  = 3'd4;
`ifdef ADF4360_LOCK_CHECK_EN
   localparam logic [2:0] STATE_LOCK    = 3'd5;
`endif

   localparam logic [2:0] STEP_CE1 = 3'd0;
   localparam logic [2:0] STEP_R   = 3'd1;
   localparam logic [2:0] STEP_C   = 3'd2;
   localparam logic [2:0] STEP_N   = 3'd3;
   localparam logic [2:0] STEP_CE0 = 3'd4;

   logic [2:0]  state_q, state_d;
   logic [2:0]  step_q, step_d;
   logic [1:0]  sub_q, sub_d;        // cycle counter inside ISSUE / GUARD
   logic [23:0] settle_q, settle_d;
   logic [21:0] r_q, r_d, c_q, c_d, n_q, n_d;
   logic [23:0] cmd_q, cmd_d;
   logic        trig_q, trig_d;
   logic        busy_q, busy_d;
   logic        done_q, done_d;
   logic        locked_q, locked_d;
   logic        error_q, error_d;
`ifdef ADF4360_LOCK_CHECK_EN
   logic [23:0] hold_q, hold_d;      // consecutive lock_i high cycles
   logic [23:0] tmo_q, tmo_d;        // cycles spent waiting for lock
`else
   logic        unused_lock;
   assign unused_lock = ^{lock_i, LOCK_HOLD, LOCK_TIMEOUT};
`endif

   logic        issue_en;
   logic [2:0]  issue_step;
   logic        finish_en;

   // Next-state logic: step sequencing, delays and command selection
   always_comb begin
      state_d    = state_q;
      step_d     = step_q;
      sub_d      = sub_q;
      settle_d   = settle_q;
      r_d        = r_q;
      c_d        = c_q;
      n_d        = n_q;
      cmd_d      = cmd_q;
      trig_d     = 1'b0;
      busy_d     = busy_q;
      done_d     = 1'b0;
      locked_d   = locked_q;
      error_d    = error_q;
`ifdef ADF4360_LOCK_CHECK_EN
      hold_d     = hold_q;
      tmo_d      = tmo_q;
`endif
      issue_en   = 1'b0;
      issue_step = STEP_CE1;
      finish_en  = 1'b0;

      case (state_q)
         STATE_IDLE: begin
            // Power-down takes priority over start when both are requested
            if (pd_i) begin
               busy_d     = 1'b1;
               locked_d   = 1'b0;
               issue_en   = 1'b1;
               issue_step = STEP_CE0;
            end else if (start_i) begin
               r_d        = r_data_i;
               c_d        = c_data_i;
               n_d        = n_data_i;
               error_d    = 1'b0;
               locked_d   = 1'b0;
               busy_d     = 1'b1;
               issue_en   = 1'b1;
               issue_step = STEP_CE1;
            end
         end
         STATE_ISSUE: begin
            // Trigger stays high for two cycles so the controller sees it
            if (sub_q == 2'd0) begin
               sub_d  = 2'd1;
               trig_d = 1'b1;
            end else begin
               sub_d   = 2'd0;
               state_d = STATE_GUARD;
            end
         end
         STATE_GUARD: begin
            // Ignore ready until the controller has registered the trigger
            // and dropped its idle flag
            if (sub_q == 2'd3) begin
               sub_d   = 2'd0;
               state_d = STATE_WAITRDY;
            end else begin
               sub_d = sub_q + 2'd1;
            end
         end
         STATE_WAITRDY: begin
            if (bus.ready) begin
               case (step_q)
                  STEP_CE1: begin
                     if (CE_SETTLE == 24'd0) begin
                        issue_en   = 1'b1;
                        issue_step = STEP_R;
                     end else begin
                        settle_d = CE_SETTLE;
                        state_d  = STATE_SETTLE;
                     end
                  end
                  STEP_R: begin
                     issue_en   = 1'b1;
                     issue_step = STEP_C;
                  end
                  STEP_C: begin
                     if (CN_DELAY == 24'd0) begin
                        issue_en   = 1'b1;
                        issue_step = STEP_N;
                     end else begin
                        settle_d = CN_DELAY;
                        state_d  = STATE_SETTLE;
                     end
                  end
                  STEP_N: begin
`ifdef ADF4360_LOCK_CHECK_EN
                     hold_d  = '0;
                     tmo_d   = '0;
                     state_d = STATE_LOCK;
`else
                     finish_en = 1'b1;
`endif
                  end
                  default: finish_en = 1'b1;
               endcase
            end
         end
         STATE_SETTLE: begin
            // Loaded with k at entry; the follow-on write issues k edges later
            if (settle_q <= 24'd1) begin
               settle_d   = '0;
               issue_en   = 1'b1;
               issue_step = (step_q == STEP_CE1) ? STEP_R : STEP_N;
            end else begin
               settle_d = settle_q - 24'd1;
            end
         end
`ifdef ADF4360_LOCK_CHECK_EN
         STATE_LOCK: begin
            tmo_d  = tmo_q + 24'd1;
            hold_d = lock_i ? hold_q + 24'd1 : 24'd0;
            if (lock_i && (hold_q + 24'd1 >= LOCK_HOLD)) begin
               locked_d  = 1'b1;
               hold_d    = '0;
               tmo_d     = '0;
               finish_en = 1'b1;
            end else if (tmo_q + 24'd1 >= LOCK_TIMEOUT) begin
               error_d   = 1'b1;
               locked_d  = 1'b0;
               hold_d    = '0;
               tmo_d     = '0;
               finish_en = 1'b1;
            end
         end
`endif
         default: state_d = STATE_IDLE;
      endcase

      if (issue_en) begin
         state_d = STATE_ISSUE;
         step_d  = issue_step;
         sub_d   = 2'd0;
         trig_d  = 1'b1;
         case (issue_step)
            STEP_CE1: cmd_d = {2'b11, 21'd0, 1'b1};
            STEP_R:   cmd_d = {2'b01, r_q};
            STEP_C:   cmd_d = {2'b00, c_q};
            STEP_N:   cmd_d = {2'b10, n_q};
            default:  cmd_d = {2'b11, 21'd0, 1'b0};
         endcase
      end

      if (finish_en) begin
         busy_d  = 1'b0;
         done_d  = 1'b1;
         state_d = STATE_IDLE;
      end
   end

   // State registers; reset forces every output low immediately
   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         state_q  <= STATE_IDLE;
         step_q   <= STEP_CE1;
         sub_q    <= '0;
         settle_q <= '0;
         r_q      <= '0;
         c_q      <= '0;
         n_q      <= '0;
         cmd_q    <= '0;
         trig_q   <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         locked_q <= 1'b0;
         error_q  <= 1'b0;
`ifdef ADF4360_LOCK_CHECK_EN
         hold_q   <= '0;
         tmo_q    <= '0;
`endif
      end else begin
         state_q  <= state_d;
         step_q   <= step_d;
         sub_q    <= sub_d;
         settle_q <= settle_d;
         r_q      <= r_d;
         c_q      <= c_d;
         n_q      <= n_d;
         cmd_q    <= cmd_d;
         trig_q   <= trig_d;
         busy_q   <= busy_d;
         done_q   <= done_d;
         locked_q <= locked_d;
         error_q  <= error_d;
`ifdef ADF4360_LOCK_CHECK_EN
         hold_q   <= hold_d;
         tmo_q    <= tmo_d;
`endif
      end
   end

   assign bus.cmd  = cmd_q;
   assign bus.trig = trig_q;
   assign busy_o   = busy_q;
   assign done_o   = done_q;
   assign locked_o = locked_q;
   assign error_o  = error_q;

endmodule

// File: tb/tb_adf4360_seq.sv
// Self-checking bench for adf4360_seq. Expected trigger/done events are pushed
// to a scoreboard queue when stimulus is driven; a monitor pops and compares
// them as the DUT produces them.
module tb_adf4360_seq;

`ifdef ADF4360_LOCK_CHECK_EN
   localparam int LOCK_EXTRA = 4;
   localparam bit EXP_LOCKED = 1'b1;
`else
   localparam int LOCK_EXTRA = 0;
   localparam bit EXP_LOCKED = 1'b0;
`endif

   typedef struct {
      bit          is_done;
      int          cyc;
      logic [23:0] cmd;
   } ev_t;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        start = 1'b0;
   logic        pd = 1'b0;
   logic [21:0] r_data = '0, c_data = '0, n_data = '0;
   logic        lock = 1'b0;
   logic        busy, done, locked, error;
   int          cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;
   ev_t         exp_q[$];

   adf4360_seq_if bus_if ();

   adf4360_seq #(
      .CE_SETTLE   (24'd4),
      .CN_DELAY    (24'd8),
      .LOCK_TIMEOUT(24'd100),
      .LOCK_HOLD   (24'd4)
   ) dut (
      .clk_i    (clk),
      .reset_n_i(reset_n),
      .start_i  (start),
      .pd_i     (pd),
      .r_data_i (r_data),
      .c_data_i (c_data),
      .n_data_i (n_data),
      .lock_i   (lock),
      .bus      (bus_if),
      .busy_o   (busy),
      .done_o   (done),
      .locked_o (locked),
      .error_o  (error)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Monitor: trigger rises and done pulses are popped from the scoreboard
   logic        trig_prev = 1'b0;
   int          trig_len = 0;
   logic [23:0] cur_cmd = '0;
   always @(negedge clk) begin
      ev_t e;
      if (!reset_n) begin
         trig_prev = 1'b0;
         trig_len  = 0;
      end else begin
         if (bus_if.trig && !trig_prev) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_trig cyc=%0d cmd=%06h", cyc, bus_if.cmd);
            end else begin
               e = exp_q.pop_front();
               if (e.is_done || e.cyc != cyc || bus_if.cmd !== e.cmd) begin
                  n_fail++;
                  $display("FAIL trig_event got cyc=%0d cmd=%06h expected done=%0b cyc=%0d cmd=%06h",
                           cyc, bus_if.cmd, e.is_done, e.cyc, e.cmd);
               end else
                  $display("trig cyc=%0d cmd=%06h", cyc, bus_if.cmd);
            end
            cur_cmd  = bus_if.cmd;
            trig_len = 1;
         end else if (bus_if.trig) begin
            trig_len++;
         end else if (trig_prev) begin
            n_checks++;
            if (trig_len != 2) begin
               n_fail++;
               $display("FAIL trig_width got=%0d expected=2 cyc=%0d", trig_len, cyc);
            end
         end
         if (busy && !(bus_if.trig && !trig_prev)) begin
            n_checks++;
            if (bus_if.cmd !== cur_cmd) begin
               n_fail++;
               $display("FAIL cmd_stable got=%06h expected=%06h cyc=%0d", bus_if.cmd, cur_cmd, cyc);
            end
         end
         if (done) begin
            n_checks++;
            if (exp_q.size() == 0) begin
               n_fail++;
               $display("FAIL unexpected_done cyc=%0d", cyc);
            end else begin
               e = exp_q.pop_front();
               if (!e.is_done || e.cyc != cyc || busy !== 1'b0) begin
                  n_fail++;
                  $display("FAIL done_event got cyc=%0d busy=%0b expected done=%0b cyc=%0d busy=0",
                           cyc, busy, e.is_done, e.cyc);
               end else
                  $display("done cyc=%0d", cyc);
            end
         end
         trig_prev = bus_if.trig;
      end
   end

   // Full program sequence accepted at edge b+1; s delays C onward, lx delays done
   task automatic push_seq(input int b, input int s, input int lx,
                           input logic [21:0] r, input logic [21:0] c, input logic [21:0] n);
      exp_q.push_back('{1'b0, b + 1,      24'hC00001});
      exp_q.push_back('{1'b0, b + 12,     {2'b01, r}});
      exp_q.push_back('{1'b0, b + 19 + s, {2'b00, c}});
      exp_q.push_back('{1'b0, b + 34 + s, {2'b10, n}});
      exp_q.push_back('{1'b1, b + 41 + s + lx, 24'h0});
   endtask

   task automatic pulse_start();
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
   endtask

   task automatic wait_until(input int target);
      while (cyc < target) @(negedge clk);
   endtask

   task automatic drain(input int budget, output bit ok);
      int n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      ok = (exp_q.size() == 0);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++;
      if ({bus_if.cmd, bus_if.trig, busy, done, locked, error} !== 30'd0) begin
         n_fail++;
         $display("FAIL reset_outputs got cmd=%06h trig=%0b busy=%0b done=%0b locked=%0b error=%0b expected all 0",
                  bus_if.cmd, bus_if.trig, busy, done, locked, error);
      end
      reset_n = 1'b1;
      repeat (2) @(negedge clk);
      n_checks++;
      if ({bus_if.trig, busy, done} !== 3'd0) begin
         n_fail++;
         $display("FAIL idle_after_reset got trig=%0b busy=%0b done=%0b expected 0", bus_if.trig, busy, done);
      end
   endtask

   task automatic test_sequence();
      int b;
      bit ok;
      logic [21:0] r, c, n;
      r = 22'($urandom()); c = 22'($urandom()); n = 22'($urandom());
      r_data = r; c_data = c; n_data = n;
      lock = EXP_LOCKED;
      b = cyc;
      push_seq(b, 0, LOCK_EXTRA, r, c, n);
      pulse_start();
      // Inputs change mid-sequence; latched payloads must be used
      r_data = ~r; c_data = ~c; n_data = ~n;
      wait_until(b + 20);
      n_checks++;
      if (busy !== 1'b1) begin
         n_fail++;
         $display("FAIL busy_mid_seq got=%0b expected=1", busy);
      end
      drain(200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL seq_timeout pending=%0d expected=0", exp_q.size());
      end
      n_checks++;
      if (locked !== EXP_LOCKED || error !== 1'b0) begin
         n_fail++;
         $display("FAIL seq_status got locked=%0b error=%0b expected locked=%0b error=0", locked, error, EXP_LOCKED);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_ready_stall();
      int b;
      bit ok;
      logic [21:0] r, c, n;
      r = 22'($urandom()); c = 22'($urandom()); n = 22'($urandom());
      r_data = r; c_data = c; n_data = n;
      b = cyc;
      push_seq(b, 15, LOCK_EXTRA, r, c, n);
      pulse_start();
      wait_until(b + 13);
      bus_if.ready = 1'b0;          // sampled low at edges b+14..b+33
      wait_until(b + 33);
      bus_if.ready = 1'b1;
      drain(200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL stall_timeout pending=%0d expected=0", exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_pd_priority();
      int b;
      bit ok;
      b = cyc;
      exp_q.push_back('{1'b0, b + 1, 24'hC00000});
      exp_q.push_back('{1'b1, b + 8, 24'h0});
      start = 1'b1;
      pd = 1'b1;
      @(negedge clk);
      start = 1'b0;
      pd = 1'b0;
      n_checks++;
      if (busy !== 1'b1 || locked !== 1'b0) begin
         n_fail++;
         $display("FAIL pd_accept got busy=%0b locked=%0b expected busy=1 locked=0", busy, locked);
      end
      // Requests while busy are ignored
      wait_until(b + 4);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      drain(50, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL pd_timeout pending=%0d expected=0", exp_q.size());
      end
      repeat (6) @(negedge clk);
      n_checks++;
      if (busy !== 1'b0 || locked !== 1'b0) begin
         n_fail++;
         $display("FAIL pd_final got busy=%0b locked=%0b expected 0 0", busy, locked);
      end
   endtask

`ifdef ADF4360_LOCK_CHECK_EN
   task automatic test_lock_hold();
      int b;
      bit ok;
      bit pat[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
      b = cyc;
      lock = 1'b0;
      push_seq(b, 0, 7, r_data, c_data, n_data);
      pulse_start();
      wait_until(b + 41);
      for (int k = 0; k < 7; k++) begin
         lock = pat[k];
         n_checks++;
         if (locked !== 1'b0) begin
            n_fail++;
            $display("FAIL lock_early got=%0b expected=0 cyc=%0d", locked, cyc);
         end
         @(negedge clk);
      end
      n_checks++;
      if (locked !== 1'b1 || done !== 1'b1) begin
         n_fail++;
         $display("FAIL lock_set got locked=%0b done=%0b expected 1 1", locked, done);
      end
      drain(20, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL lock_timeout_wait pending=%0d expected=0", exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_lock_timeout();
      int b;
      bit ok;
      b = cyc;
      lock = 1'b0;
      push_seq(b, 0, 100, r_data, c_data, n_data);
      pulse_start();
      wait_until(b + 140);
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("FAIL error_early got=%0b expected=0", error);
      end
      @(negedge clk);
      n_checks++;
      if (error !== 1'b1 || done !== 1'b1 || locked !== 1'b0) begin
         n_fail++;
         $display("FAIL timeout_flag got error=%0b done=%0b locked=%0b expected 1 1 0", error, done, locked);
      end
      drain(20, ok);
      repeat (3) @(negedge clk);
      // Next start clears the sticky error
      lock = 1'b1;
      b = cyc;
      push_seq(b, 0, 4, r_data, c_data, n_data);
      pulse_start();
      n_checks++;
      if (error !== 1'b0) begin
         n_fail++;
         $display("FAIL error_clear got=%0b expected=0", error);
      end
      drain(200, ok);
      n_checks++;
      if (!ok || locked !== 1'b1) begin
         n_fail++;
         $display("FAIL relock got pending=%0d locked=%0b expected 0 1", exp_q.size(), locked);
      end
      repeat (3) @(negedge clk);
   endtask
`else
   task automatic test_lock_ignored();
      int b;
      int n = 0;
      b = cyc;
      push_seq(b, 0, 0, r_data, c_data, n_data);
      pulse_start();
      while (exp_q.size() != 0 && n < 200) begin
         lock = 1'($urandom_range(0, 1));
         @(negedge clk);
         n++;
      end
      n_checks++;
      if (exp_q.size() != 0 || locked !== 1'b0 || error !== 1'b0) begin
         n_fail++;
         $display("FAIL lock_ignored got pending=%0d locked=%0b error=%0b expected 0 0 0",
                  exp_q.size(), locked, error);
      end
      lock = 1'b0;
      repeat (3) @(negedge clk);
   endtask
`endif

   task automatic test_reset_mid();
      int b;
      bit ok;
      lock = EXP_LOCKED;
      b = cyc;
      push_seq(b, 0, LOCK_EXTRA, r_data, c_data, n_data);
      pulse_start();
      wait_until(b + 28);           // inside the C->N settle
      #1 reset_n = 1'b0;
      #1;
      n_checks++;
      if ({bus_if.cmd, bus_if.trig, busy, done, locked, error} !== 30'd0) begin
         n_fail++;
         $display("FAIL async_reset got cmd=%06h trig=%0b busy=%0b done=%0b locked=%0b error=%0b expected all 0",
                  bus_if.cmd, bus_if.trig, busy, done, locked, error);
      end
      exp_q.delete();
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      b = cyc;
      push_seq(b, 0, LOCK_EXTRA, r_data, c_data, n_data);
      pulse_start();
      drain(200, ok);
      n_checks++;
      if (!ok) begin
         n_fail++;
         $display("FAIL rerun_timeout pending=%0d expected=0", exp_q.size());
      end
      repeat (3) @(negedge clk);
   endtask

   initial begin
      bus_if.ready = 1'b1;
      @(negedge clk);
      test_reset();
      test_sequence();
      test_ready_stall();
      test_pd_priority();
`ifdef ADF4360_LOCK_CHECK_EN
      test_lock_hold();
      test_lock_timeout();
`else
      test_lock_ignored();
`endif
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
